if_fetch_stage: RTL
===================

# if_fetch_stage

Instruction-fetch stage of the 5-stage pipeline: owns the fetch PC, drives the instruction-memory request, and registers the fetched word into the IF/ID pipeline latch consumed by decode. It accepts the hazard-detection stall and the ID-stage branch/jump redirect. It holds one fetched word in a skid register when a stall arrives in the same cycle as memory data, so no fetch is lost or repeated.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC value after reset
- NOP_INSTR, 32'h0000_0000, word placed in ifid_instr_o on flush/bubble
- clk_i  input  1  clock, all state updates on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- start_i  input  1  run enable; 0 halts fetch
- hd_stall_i  input  1  hazard-detection stall; hold PC and IF/ID
- flush_i  input  1  taken branch/jump in ID; redirect fetch
- redirect_pc_i  input  32  target PC, valid with flush_i
- imem_req_o  output  1  fetch request
- imem_addr_o  output  32  fetch address (= pc_o)
- imem_ready_i  input  1  imem_rdata_i valid this cycle
- imem_rdata_i  input  32  instruction word
- pc_o  output  32  current fetch PC
- ifid_valid_o  output  1  IF/ID latch holds a real instruction
- ifid_pc_o  output  32  PC of latched instruction
- ifid_pc4_o  output  32  ifid_pc_o + 4
- ifid_instr_o  output  32  latched instruction
- stall_cnt_o, flush_cnt_o  output  32 each  present only with FETCH_PERF_CNT_EN

## Operation
- Reset (async, rst_n_i=0): state IDLE, pc_o=RESET_PC, ifid_valid_o=0, ifid_pc_o=0, ifid_pc4_o=0, ifid_instr_o=NOP_INSTR, skid empty, counters 0, imem_req_o=0.
- States: IDLE, FETCH, STALL. Per-edge priority: flush_i > !start_i > hd_stall_i > imem_ready_i.
- IDLE: imem_req_o=0. start_i=1 -> FETCH. IF/ID unchanged.
- FETCH: imem_req_o=1, imem_addr_o=pc_o.
  - ready & !stall: IF/ID <= {valid=1, pc_o, pc_o+4, imem_rdata_i}; pc_o <= pc_o+4.
  - ready & stall: skid <= imem_rdata_i; -> STALL; pc_o, IF/ID held.
  - !ready & !stall: ifid_valid_o <= 0, ifid_instr_o <= NOP_INSTR (bubble); pc_o held.
  - !ready & stall: everything held.
- STALL: imem_req_o=0. stall still 1: hold. stall=0: IF/ID <= {1, pc_o, pc_o+4, skid}; pc_o <= pc_o+4; -> FETCH.
- flush_i=1 (any non-IDLE state, overrides stall): pc_o <= redirect_pc_i; ifid_valid_o <= 0; ifid_instr_o <= NOP_INSTR; skid discarded; -> FETCH if start_i else IDLE. Data returned in the flush cycle is dropped. flush_i in IDLE: pc_o <= redirect_pc_i only.
- start_i=0 in FETCH/STALL (no flush): -> IDLE; skid discarded; pc_o held at the unconsumed address; ifid_valid_o <= 0.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check; redirect_pc_i is used as-is.

## Timing
- Single clock domain; imem_ready_i/imem_rdata_i sampled at the rising edge. Combinational memory response is allowed.
- Fetch latency: ready at edge N -> ifid_valid_o=1 after edge N.
- Throughput: 1 instruction/cycle with imem_ready_i tied 1 and no stalls.
- Redirect: flush at edge N -> imem_addr_o=redirect_pc_i in cycle N+1; the first redirected instruction is valid in IF/ID after edge N+1 at earliest.
- Stall release from STALL: the skid word enters IF/ID at the release edge; the next request is issued the following cycle (1 bubble-free handoff, 1 request-free cycle).
- Reset assertion mid-operation takes effect immediately; all outputs return to reset values without a clock.

## Configuration
- FETCH_PERF_CNT_EN defined: stall_cnt_o increments each cycle hd_stall_i=1 while state != IDLE. flush_cnt_o increments each cycle flush_i=1. Both wrap at 2^32 and are reset by rst_n_i.
- Undefined: counters and both ports are absent. Fetch behaviour is identical.

## Test plan
- Reset then start_i=1, ready=1, rdata=PC-derived: IF/ID shows PC 0,4,8… on consecutive cycles with valid=1 and pc4 = pc+4.
- Stall coinciding with ready at PC 0x10 for 3 cycles: pc_o stays 0x10, imem_req_o=0 in STALL. On release, IF/ID gets {0x10, 0x14, skid word}, then fetch resumes at 0x14. No duplicate or missing PC.
- flush_i with redirect 0x40 during stall: stall ignored; next cycle imem_addr_o=0x40 and ifid_valid_o=0, ifid_instr_o=NOP_INSTR.
- ready low for 2 cycles: two bubbles (valid=0), pc_o constant, then normal fetch.
- pc_o=32'hFFFF_FFFC fetched -> pc_o=0. rst_n_i pulsed mid-FETCH -> pc_o=RESET_PC and IDLE immediately.
- With FETCH_PERF_CNT_EN: 3 stall cycles + 2 flushes -> stall_cnt_o=3, flush_cnt_o=2.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage. Owns the fetch PC, issues the
// instruction-memory request and registers the fetched word into the IF/ID
// latch. A one-word skid register catches memory data that arrives in the
// same cycle as a hazard stall, so no fetch is lost or repeated.
// Optional build macro: FETCH_PERF_CNT_EN adds stall/flush event counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        hd_stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] skid_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic [31:0] ifid_instr_q;

  // PC + 4, wrapping modulo 2^32.
  logic [31:0] pc_plus4_d;
  assign pc_plus4_d = pc_q + 32'd4;

  // Fetch FSM with PC, skid and IF/ID latch; priority flush > !start > stall > ready.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      skid_q       <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      // Redirect wins over everything; any data returned this cycle is dropped.
      pc_q <= redirect_pc_i;
      if (state_q != IDLE) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
        skid_q       <= NOP_INSTR;
        state_q      <= start_i ? FETCH : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) state_q <= FETCH;
        end
        FETCH: begin
          if (!start_i) begin
            // Halt: the PC stays at the address not yet consumed.
            state_q      <= IDLE;
            ifid_valid_q <= 1'b0;
            skid_q       <= NOP_INSTR;
          end else if (hd_stall_i) begin
            if (imem_ready_i) begin
              skid_q  <= imem_rdata_i;
              state_q <= STALL;
            end
          end else if (imem_ready_i) begin
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= pc_q;
            ifid_pc4_q   <= pc_plus4_d;
            ifid_instr_q <= imem_rdata_i;
            pc_q         <= pc_plus4_d;
          end else begin
            // Memory not ready: insert a bubble, keep requesting the same PC.
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
          end
        end
        STALL: begin
          if (!start_i) begin
            state_q      <= IDLE;
            ifid_valid_q <= 1'b0;
            skid_q       <= NOP_INSTR;
          end else if (!hd_stall_i) begin
            // Hand the captured word to decode; the next request follows next cycle.
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= pc_q;
            ifid_pc4_q   <= pc_plus4_d;
            ifid_instr_q <= skid_q;
            pc_q         <= pc_plus4_d;
            state_q      <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_o   = (state_q == FETCH);
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Event counters: stall cycles outside IDLE and flush cycles, wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (hd_stall_i && (state_q != IDLE)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
